// File: rtl/k423_lsu_pkg.sv
// Shared types and helpers for the LSU controller: FSM states, access size codes,
// byte-enable generation, misalignment test and load sign/zero extension.
package k423_lsu_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_RSP  = 2'd2
   } state_t;

   localparam logic [1:0] SIZE_BYTE = 2'd0;
   localparam logic [1:0] SIZE_HALF = 2'd1;
   localparam logic [1:0] SIZE_WORD = 2'd2;

   // Attributes of the captured access that are needed again when the response returns.
   typedef struct packed {
      logic       load;
      logic       uns;
      logic [1:0] size;
      logic [1:0] lane;
   } req_info_t;

   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
      return ((size == SIZE_HALF) && lane[0]) || (size[1] && (lane != 2'b00));
   endfunction

   function automatic logic [3:0] lane_wen(input logic [1:0] size, input logic [1:0] lane);
      logic [3:0] base;
      case (size)
         SIZE_BYTE: base = 4'b0001;
         SIZE_HALF: base = 4'b0011;
         default:   base = 4'b1111;
      endcase
      return base << lane;
   endfunction

   function automatic logic [31:0] extend_load(input logic [31:0] d, input logic [1:0] size,
                                               input logic uns);
      case (size)
         SIZE_BYTE: return {{24{~uns & d[7]}}, d[7:0]};
         SIZE_HALF: return {{16{~uns & d[15]}}, d[15:0]};
         default:   return d;
      endcase
   endfunction

endpackage

// File: rtl/k423_lsu_ctrl_if.sv
// Bundle of the EX-side request, dmem request/response and writeback/error signals.
// master = LSU controller, slave = the surrounding pipeline and memory.
interface k423_lsu_ctrl_if #(
   parameter int XLEN   = 32,
   parameter int ADDR_W = 32
);
   logic              ex_req_vld;
   logic              ex_req_load;
   logic              ex_req_unsigned;
   logic [1:0]        ex_req_size;
   logic [ADDR_W-1:0] ex_req_addr;
   logic [XLEN-1:0]   ex_req_wdata;
   logic              flush;
   logic              lsu_stall;
   logic              mem_req_vld;
   logic [XLEN/8-1:0] mem_req_wen;
   logic [ADDR_W-1:0] mem_req_addr;
   logic [XLEN-1:0]   mem_req_wdata;
   logic              mem_req_rdy;
   logic              mem_rsp_vld;
   logic [XLEN-1:0]   mem_rsp_rdata;
   logic              wb_vld;
   logic [XLEN-1:0]   wb_rdata;
   logic              err_misalign;
   logic              err_timeout;

   modport master (
      input  ex_req_vld, ex_req_load, ex_req_unsigned, ex_req_size, ex_req_addr, ex_req_wdata,
      input  flush, mem_req_rdy, mem_rsp_vld, mem_rsp_rdata,
      output lsu_stall, mem_req_vld, mem_req_wen, mem_req_addr, mem_req_wdata,
      output wb_vld, wb_rdata, err_misalign, err_timeout
   );

   modport slave (
      output ex_req_vld, ex_req_load, ex_req_unsigned, ex_req_size, ex_req_addr, ex_req_wdata,
      output flush, mem_req_rdy, mem_rsp_vld, mem_rsp_rdata,
      input  lsu_stall, mem_req_vld, mem_req_wen, mem_req_addr, mem_req_wdata,
      input  wb_vld, wb_rdata, err_misalign, err_timeout
   );
endinterface

// File: rtl/k423_lsu_align.sv
// Combinational load path: moves the addressed byte lane down to bit 0 and
// sign- or zero-extends according to the access size.
module k423_lsu_align
   import k423_lsu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] rdata,
   input  logic [1:0]      lane,
   input  logic [1:0]      size,
   input  logic            uns,
   output logic [XLEN-1:0] data
);
   localparam int NB = XLEN / 8;

   logic [XLEN-1:0] shifted [NB];

   genvar gi;
   for (gi = 0; gi < NB; gi++) begin : g_lane
      assign shifted[gi] = rdata >> (8 * gi);
   end

   always_comb begin
      data = extend_load(shifted[lane], size, uns);
   end

endmodule

// File: rtl/k423_lsu_ctrl.sv
// LSU sequencer: one outstanding dmem access, lane-aligned stores, extended load results,
// with misalignment, timeout and flush handling.
module k423_lsu_ctrl
   import k423_lsu_pkg::*;
#(
   parameter int XLEN        = 32,
   parameter int ADDR_W      = 32,
   parameter int TIMEOUT_CYC = 64
) (
   input logic             clk,
   input logic             rst,
   k423_lsu_ctrl_if.master bus
);
   localparam int NB    = XLEN / 8;
   localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

   state_t            state_reg, state_next;
   req_info_t         info_reg, info_next;
   logic              drop_reg, drop_next;
   logic [CNT_W-1:0]  cnt_reg, cnt_next;
   logic              mem_vld_reg, mem_vld_next;
   logic [NB-1:0]     mem_wen_reg, mem_wen_next;
   logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
   logic [XLEN-1:0]   mem_wdata_reg, mem_wdata_next;
   logic              wb_vld_reg, wb_vld_next;
   logic [XLEN-1:0]   wb_rdata_reg, wb_rdata_next;
   logic              err_mis_reg, err_mis_next;
   logic              err_to_reg, err_to_next;
   logic              stall;

   logic [1:0]        lane;
   logic              misaligned;
   logic              timeout_hit;
   logic [XLEN-1:0]   load_data;

   assign lane        = bus.ex_req_addr[1:0];
   assign misaligned  = is_misaligned(bus.ex_req_size, lane);
   assign timeout_hit = (cnt_reg == CNT_LAST);

   k423_lsu_align #(.XLEN(XLEN)) u_align (
      .rdata (bus.mem_rsp_rdata),
      .lane  (info_reg.lane),
      .size  (info_reg.size),
      .uns   (info_reg.uns),
      .data  (load_data)
   );

   always_comb begin
      state_next     = state_reg;
      info_next      = info_reg;
      drop_next      = drop_reg;
      cnt_next       = cnt_reg;
      mem_vld_next   = 1'b0;
      mem_wen_next   = mem_wen_reg;
      mem_addr_next  = mem_addr_reg;
      mem_wdata_next = mem_wdata_reg;
      wb_vld_next    = 1'b0;
      wb_rdata_next  = wb_rdata_reg;
      err_mis_next   = 1'b0;
      err_to_next    = 1'b0;
      stall          = 1'b0;

      case (state_reg)
         ST_IDLE: begin
            stall = bus.ex_req_vld & ~misaligned;
            if (bus.ex_req_vld && !bus.flush) begin
               if (misaligned) begin
                  err_mis_next = 1'b1;
               end else begin
                  state_next     = ST_REQ;
                  info_next      = '{load: bus.ex_req_load, uns: bus.ex_req_unsigned,
                                     size: bus.ex_req_size, lane: lane};
                  drop_next      = 1'b0;
                  cnt_next       = '0;
                  mem_vld_next   = 1'b1;
                  mem_addr_next  = {bus.ex_req_addr[ADDR_W-1:2], 2'b00};
                  mem_wen_next   = bus.ex_req_load ? '0 : lane_wen(bus.ex_req_size, lane);
                  mem_wdata_next = bus.ex_req_load ? '0 : (bus.ex_req_wdata << {lane, 3'b000});
               end
            end
         end

         ST_REQ: begin
            stall    = 1'b1;
            cnt_next = cnt_reg + 1'b1;
            // Acceptance beats both flush and timeout: once taken, the access must be answered.
            if (bus.mem_req_rdy) begin
               state_next = ST_RSP;
               drop_next  = bus.flush;
            end else if (bus.flush) begin
               state_next = ST_IDLE;
            end else if (timeout_hit) begin
               state_next  = ST_IDLE;
               err_to_next = 1'b1;
               stall       = 1'b0;
            end else begin
               mem_vld_next = 1'b1;
            end
         end

         ST_RSP: begin
            cnt_next = cnt_reg + 1'b1;
            if (bus.mem_rsp_vld) begin
               state_next = ST_IDLE;
               if (info_reg.load && !drop_reg && !bus.flush) begin
                  wb_vld_next   = 1'b1;
                  wb_rdata_next = load_data;
               end
            end else begin
               if (bus.flush) drop_next = 1'b1;
               if (timeout_hit) begin
                  state_next  = ST_IDLE;
                  err_to_next = 1'b1;
               end else begin
                  stall = 1'b1;
               end
            end
         end

         default: state_next = ST_IDLE;
      endcase

      if (rst) stall = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= ST_IDLE;
         info_reg      <= '0;
         drop_reg      <= 1'b0;
         cnt_reg       <= '0;
         mem_vld_reg   <= 1'b0;
         mem_wen_reg   <= '0;
         mem_addr_reg  <= '0;
         mem_wdata_reg <= '0;
         wb_vld_reg    <= 1'b0;
         wb_rdata_reg  <= '0;
         err_mis_reg   <= 1'b0;
         err_to_reg    <= 1'b0;
      end else begin
         state_reg     <= state_next;
         info_reg      <= info_next;
         drop_reg      <= drop_next;
         cnt_reg       <= cnt_next;
         mem_vld_reg   <= mem_vld_next;
         mem_wen_reg   <= mem_wen_next;
         mem_addr_reg  <= mem_addr_next;
         mem_wdata_reg <= mem_wdata_next;
         wb_vld_reg    <= wb_vld_next;
         wb_rdata_reg  <= wb_rdata_next;
         err_mis_reg   <= err_mis_next;
         err_to_reg    <= err_to_next;
      end
   end

   assign bus.lsu_stall     = stall;
   assign bus.mem_req_vld   = mem_vld_reg;
   assign bus.mem_req_wen   = mem_wen_reg;
   assign bus.mem_req_addr  = mem_addr_reg;
   assign bus.mem_req_wdata = mem_wdata_reg;
   assign bus.wb_vld        = wb_vld_reg;
   assign bus.wb_rdata      = wb_rdata_reg;
   assign bus.err_misalign  = err_mis_reg;
   assign bus.err_timeout   = err_to_reg;

endmodule

// File: tb/tb_k423_lsu_ctrl.sv
// Scoreboard bench for k423_lsu_ctrl: directed accesses push expected bus events,
// a negedge monitor pops and compares every accepted request, writeback and error pulse.
module tb_k423_lsu_ctrl;
   import k423_lsu_pkg::*;

   localparam logic [1:0] K_REQ = 2'd0;
   localparam logic [1:0] K_WB  = 2'd1;
   localparam logic [1:0] K_MIS = 2'd2;
   localparam logic [1:0] K_TO  = 2'd3;

   typedef struct packed {
      logic [1:0]  kind;
      logic [3:0]  wen;
      logic [31:0] addr;
      logic [31:0] data;
      logic        chk_data;
   } ev_t;

   logic  clk = 1'b0;
   logic  rst = 1'b1;
   int    checks = 0;
   int    errors = 0;
   ev_t   exp_q[$];
   string name_q[$];

   k423_lsu_ctrl_if #(.XLEN(32), .ADDR_W(32)) bus ();

   k423_lsu_ctrl #(.XLEN(32), .ADDR_W(32), .TIMEOUT_CYC(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog act=running exp=finished");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%h exp=%h", nm, act, exp);
      end else begin
         $display("ok   %s = %h", nm, act);
      end
   endtask

   task automatic push(input string nm, input logic [1:0] kind, input logic [3:0] wen,
                       input logic [31:0] addr, input logic [31:0] data, input logic cd);
      ev_t e;
      e = '{kind: kind, wen: wen, addr: addr, data: data, chk_data: cd};
      exp_q.push_back(e);
      name_q.push_back(nm);
   endtask

   task automatic observe(input logic [1:0] kind, input logic [3:0] wen,
                          input logic [31:0] addr, input logic [31:0] data);
      ev_t   e;
      string nm;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL unexpected_event act=kind%0d data=%h exp=none", kind, data);
         return;
      end
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      chk({nm, ".kind"}, {30'b0, kind}, {30'b0, e.kind});
      if (e.kind == K_REQ) begin
         chk({nm, ".wen"}, {28'b0, wen}, {28'b0, e.wen});
         chk({nm, ".addr"}, addr, e.addr);
         if (e.chk_data) chk({nm, ".wdata"}, data, e.data);
      end else if (e.kind == K_WB) begin
         chk({nm, ".rdata"}, data, e.data);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (bus.mem_req_vld && bus.mem_req_rdy)
            observe(K_REQ, bus.mem_req_wen, bus.mem_req_addr, bus.mem_req_wdata);
         if (bus.wb_vld)       observe(K_WB, 4'b0, 32'b0, bus.wb_rdata);
         if (bus.err_misalign) observe(K_MIS, 4'b0, 32'b0, 32'b0);
         if (bus.err_timeout)  observe(K_TO, 4'b0, 32'b0, 32'b0);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_req(input logic ld, input logic un, input logic [1:0] sz,
                            input logic [31:0] addr, input logic [31:0] wd);
      bus.ex_req_vld      = 1'b1;
      bus.ex_req_load     = ld;
      bus.ex_req_unsigned = un;
      bus.ex_req_size     = sz;
      bus.ex_req_addr     = addr;
      bus.ex_req_wdata    = wd;
   endtask

   // Full access against a memory that accepts after dly cycles and answers one cycle later.
   task automatic access(input string nm, input logic ld, input logic un, input logic [1:0] sz,
                         input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rd,
                         input int dly, input logic [3:0] exp_wen, input logic [31:0] exp_wd,
                         input logic [31:0] exp_wb);
      push(nm, K_REQ, exp_wen, {addr[31:2], 2'b00}, exp_wd, !ld);
      if (ld) push(nm, K_WB, 4'b0, 32'b0, exp_wb, 1'b1);
      drive_req(ld, un, sz, addr, wd);
      #1 chk({nm, ".stall_T"}, {31'b0, bus.lsu_stall}, 32'd1);
      tick();
      bus.ex_req_vld = 1'b0;
      for (int i = 0; i < dly; i++) begin
         bus.mem_req_rdy = 1'b0;
         #1;
         chk({nm, ".hold_vld"}, {31'b0, bus.mem_req_vld}, 32'd1);
         chk({nm, ".hold_wen"}, {28'b0, bus.mem_req_wen}, {28'b0, exp_wen});
         chk({nm, ".hold_wdata"}, bus.mem_req_wdata, exp_wd);
         tick();
      end
      bus.mem_req_rdy = 1'b1;
      #1 chk({nm, ".stall_req"}, {31'b0, bus.lsu_stall}, 32'd1);
      tick();
      bus.mem_req_rdy   = 1'b0;
      bus.mem_rsp_vld   = 1'b1;
      bus.mem_rsp_rdata = rd;
      #1 chk({nm, ".stall_rsp"}, {31'b0, bus.lsu_stall}, 32'd0);
      tick();
      bus.mem_rsp_vld   = 1'b0;
      bus.mem_rsp_rdata = '0;
      tick();
   endtask

   initial begin
      bus.flush         = 1'b0;
      bus.mem_req_rdy   = 1'b0;
      bus.mem_rsp_vld   = 1'b0;
      bus.mem_rsp_rdata = '0;
      drive_req(1'b1, 1'b0, SIZE_WORD, 32'h100, 32'h0);

      // Reset with an aligned request pending: stall must stay low, outputs zero.
      tick();
      tick();
      chk("rst.stall", {31'b0, bus.lsu_stall}, 32'd0);
      chk("rst.mem_vld", {31'b0, bus.mem_req_vld}, 32'd0);
      chk("rst.wb", {31'b0, bus.wb_vld}, 32'd0);
      chk("rst.wdata", bus.mem_req_wdata, 32'd0);
      bus.ex_req_vld = 1'b0;
      rst = 1'b0;
      tick();

      access("LW_100",  1'b1, 1'b0, SIZE_WORD, 32'h100, 32'h0, 32'hDEADBEEF, 0, 4'b0000, 32'h0, 32'hDEADBEEF);
      access("LB_103",  1'b1, 1'b0, SIZE_BYTE, 32'h103, 32'h0, 32'h80123456, 0, 4'b0000, 32'h0, 32'hFFFFFF80);
      access("LBU_103", 1'b1, 1'b1, SIZE_BYTE, 32'h103, 32'h0, 32'h80123456, 0, 4'b0000, 32'h0, 32'h00000080);
      access("LHU_102", 1'b1, 1'b1, SIZE_HALF, 32'h102, 32'h0, 32'hBEEF1234, 0, 4'b0000, 32'h0, 32'h0000BEEF);
      access("LH_102",  1'b1, 1'b0, SIZE_HALF, 32'h102, 32'h0, 32'hBEEF1234, 0, 4'b0000, 32'h0, 32'hFFFFBEEF);
      access("LB_101",  1'b1, 1'b0, SIZE_BYTE, 32'h101, 32'h0, 32'h00007F00, 1, 4'b0000, 32'h0, 32'h0000007F);
      access("SH_102",  1'b0, 1'b0, SIZE_HALF, 32'h102, 32'h1234ABCD, 32'h0, 3, 4'b1100, 32'hABCD0000, 32'h0);
      access("SB_101",  1'b0, 1'b0, SIZE_BYTE, 32'h101, 32'h000000A5, 32'h0, 0, 4'b0010, 32'h0000A500, 32'h0);
      access("SW_104",  1'b0, 1'b0, SIZE_WORD, 32'h104, 32'hCAFEF00D, 32'h0, 0, 4'b1111, 32'hCAFEF00D, 32'h0);

      // Misaligned accesses: error pulse only, never a request or stall.
      push("LW_101", K_MIS, 4'b0, 32'b0, 32'b0, 1'b0);
      drive_req(1'b1, 1'b0, SIZE_WORD, 32'h101, 32'h0);
      #1 chk("LW_101.stall", {31'b0, bus.lsu_stall}, 32'd0);
      tick();
      bus.ex_req_vld = 1'b0;
      #1 chk("LW_101.no_req", {31'b0, bus.mem_req_vld}, 32'd0);
      tick();
      push("LH_103", K_MIS, 4'b0, 32'b0, 32'b0, 1'b0);
      drive_req(1'b1, 1'b0, SIZE_HALF, 32'h103, 32'h0);
      #1 chk("LH_103.stall", {31'b0, bus.lsu_stall}, 32'd0);
      tick();
      bus.ex_req_vld = 1'b0;
      tick();

      // Timeout with rdy stuck low: REQ lasts 8 cycles, stall drops in the last one.
      push("LW_200", K_TO, 4'b0, 32'b0, 32'b0, 1'b0);
      drive_req(1'b1, 1'b0, SIZE_WORD, 32'h200, 32'h0);
      tick();
      bus.ex_req_vld = 1'b0;
      for (int i = 0; i < 7; i++) tick();
      chk("TO.stall_last", {31'b0, bus.lsu_stall}, 32'd0);
      chk("TO.vld_last", {31'b0, bus.mem_req_vld}, 32'd1);
      tick();
      chk("TO.vld_drop", {31'b0, bus.mem_req_vld}, 32'd0);
      tick();
      access("LW_300", 1'b1, 1'b0, SIZE_WORD, 32'h300, 32'h0, 32'h13572468, 0, 4'b0000, 32'h0, 32'h13572468);

      // Flush while waiting for the response: access completes, writeback suppressed.
      push("FL_RSP", K_REQ, 4'b0000, 32'h100, 32'h0, 1'b0);
      drive_req(1'b1, 1'b0, SIZE_WORD, 32'h100, 32'h0);
      tick();
      bus.ex_req_vld  = 1'b0;
      bus.mem_req_rdy = 1'b1;
      tick();
      bus.mem_req_rdy = 1'b0;
      bus.flush       = 1'b1;
      #1 chk("FL_RSP.stall", {31'b0, bus.lsu_stall}, 32'd1);
      tick();
      bus.flush         = 1'b0;
      bus.mem_rsp_vld   = 1'b1;
      bus.mem_rsp_rdata = 32'h11111111;
      tick();
      bus.mem_rsp_vld = 1'b0;
      #1 chk("FL_RSP.no_wb", {31'b0, bus.wb_vld}, 32'd0);
      tick();

      // Flush in REQ before acceptance: request withdrawn next cycle.
      drive_req(1'b1, 1'b0, SIZE_WORD, 32'h100, 32'h0);
      tick();
      bus.ex_req_vld = 1'b0;
      bus.flush      = 1'b1;
      tick();
      bus.flush = 1'b0;
      chk("FL_REQ.vld_drop", {31'b0, bus.mem_req_vld}, 32'd0);
      tick();

      // Reset in REQ: everything idle next cycle, late response ignored.
      drive_req(1'b1, 1'b0, SIZE_WORD, 32'h100, 32'h0);
      tick();
      bus.ex_req_vld = 1'b0;
      rst = 1'b1;
      #1 chk("RST_REQ.stall", {31'b0, bus.lsu_stall}, 32'd0);
      tick();
      rst = 1'b0;
      chk("RST_REQ.vld", {31'b0, bus.mem_req_vld}, 32'd0);
      chk("RST_REQ.stall_after", {31'b0, bus.lsu_stall}, 32'd0);
      bus.mem_rsp_vld   = 1'b1;
      bus.mem_rsp_rdata = 32'h22222222;
      tick();
      bus.mem_rsp_vld = 1'b0;
      #1 chk("RST_REQ.no_wb", {31'b0, bus.wb_vld}, 32'd0);
      tick();
      access("LW_AFTER", 1'b1, 1'b1, SIZE_BYTE, 32'h102, 32'h0, 32'h00C30000, 0, 4'b0000, 32'h0, 32'h000000C3);
      tick();
      tick();

      chk("queue_empty", exp_q.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
